// File: rtl/instruction_buffer.sv
// instruction_buffer: circular queue between fetch/decode and dispatch.
// Accepts up to four decoded instructions per cycle in program order, shows
// up to four of the oldest entries to dispatch, retires what dispatch takes,
// and empties in a single cycle on a redirect (flush).
//
// Handshake contract: fetch presents a bundle with in_valid and in_count
// lanes; the buffer takes min(in_count, free) of them that same edge
// (num_free tells fetch how many it may send, and excess lanes set the sticky
// overflow flag). Dispatch sees out_count valid lanes and reports how many it
// consumed through deq_count; requests above out_count are clamped silently.
module instruction_buffer #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [2:0]  in_count,
   input  logic [15:0] in_opcode_flat,
   input  logic [31:0] in_imm_flat,
   input  logic [15:0] in_rt_flat,
   input  logic [15:0] in_ra_flat,
   input  logic [15:0] in_rb_flat,
   input  logic [3:0]  in_a_dep_flat,
   input  logic [3:0]  in_b_dep_flat,
   input  logic [15:0] in_a_owner_flat,
   input  logic [15:0] in_b_owner_flat,
   input  logic [3:0]  in_uses_rb_flat,
   input  logic [3:0]  in_is_ld_str_flat,
   input  logic [3:0]  in_is_fxu_flat,
   input  logic [3:0]  in_is_branch_flat,
   output logic [2:0]  num_free,
   output logic [2:0]  out_count,
   output logic [15:0] out_opcode_flat,
   output logic [31:0] out_imm_flat,
   output logic [15:0] out_rt_flat,
   output logic [15:0] out_ra_flat,
   output logic [15:0] out_rb_flat,
   output logic [3:0]  out_a_dep_flat,
   output logic [3:0]  out_b_dep_flat,
   output logic [15:0] out_a_owner_flat,
   output logic [15:0] out_b_owner_flat,
   output logic [3:0]  out_uses_rb_flat,
   output logic [3:0]  out_is_ld_str_flat,
   output logic [3:0]  out_is_fxu_flat,
   output logic [3:0]  out_is_branch_flat,
   input  logic [2:0]  deq_count,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 38;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] FOUR_C  = CW'(4);

   // Entry layout, MSB first:
   // opcode[37:34] imm[33:26] rt[25:22] ra[21:18] rb[17:14] a_dep[13]
   // b_dep[12] a_owner[11:8] b_owner[7:4] uses_rb[3] is_ld_str[2]
   // is_fxu[1] is_branch[0]
   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;

   logic [EW-1:0] in_entry  [4];
   logic [EW-1:0] out_entry [4];
   logic [2:0]    in_cnt;
   logic [2:0]    out_cnt;
   logic [CW-1:0] space;
   logic [CW-1:0] enq;
   logic [CW-1:0] deq;

   // Gather the per-lane fields of the incoming bundle into entry records.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         in_entry[k] = {in_opcode_flat[4*(3-k) +: 4],
                        in_imm_flat[8*(3-k) +: 8],
                        in_rt_flat[4*(3-k) +: 4],
                        in_ra_flat[4*(3-k) +: 4],
                        in_rb_flat[4*(3-k) +: 4],
                        in_a_dep_flat[3-k],
                        in_b_dep_flat[3-k],
                        in_a_owner_flat[4*(3-k) +: 4],
                        in_b_owner_flat[4*(3-k) +: 4],
                        in_uses_rb_flat[3-k],
                        in_is_ld_str_flat[3-k],
                        in_is_fxu_flat[3-k],
                        in_is_branch_flat[3-k]};
      end
   end

   // Enqueue/dequeue amounts and next pointer, count and overflow state.
   always_comb begin
      in_cnt     = (in_count > 3'd4) ? 3'd4 : in_count;
      // Space is taken from the pre-dequeue count: a same-cycle dequeue does
      // not free room for this cycle's enqueue.
      space      = DEPTH_C - count_q;
      out_cnt    = (count_q > FOUR_C) ? 3'd4 : 3'(count_q);
      enq        = '0;
      deq        = '0;
      overflow_d = overflow_q;
      if (in_valid && !flush) begin
         enq = (CW'(in_cnt) > space) ? space : CW'(in_cnt);
         if (CW'(in_count) > space) begin
            overflow_d = 1'b1;
         end
      end
      if (!flush) begin
         deq = (CW'(deq_count) > CW'(out_cnt)) ? CW'(out_cnt) : CW'(deq_count);
      end
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + AW'(deq);
         tail_d  = tail_q + AW'(enq);
         count_d = count_q + enq - deq;
      end
   end

   // Write accepted lanes at tail onward; pointer arithmetic wraps at DEPTH.
   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < 4; k++) begin
         if (CW'(k) < enq) begin
            mem_d[tail_q + AW'(k)] = in_entry[k];
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage; contents survive flush and are never cleared, since
   // only entries between head and head+count are ever shown.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q <= mem_d;
      end
   end

   // Present the oldest entries; lanes beyond the occupancy read as zero.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         out_entry[k] = (k < int'(out_cnt)) ? mem_q[head_q + AW'(k)] : '0;
      end
   end

   // Scatter output entries back onto the flat lane buses.
   always_comb begin
      out_opcode_flat    = '0;
      out_imm_flat       = '0;
      out_rt_flat        = '0;
      out_ra_flat        = '0;
      out_rb_flat        = '0;
      out_a_dep_flat     = '0;
      out_b_dep_flat     = '0;
      out_a_owner_flat   = '0;
      out_b_owner_flat   = '0;
      out_uses_rb_flat   = '0;
      out_is_ld_str_flat = '0;
      out_is_fxu_flat    = '0;
      out_is_branch_flat = '0;
      for (int k = 0; k < 4; k++) begin
         out_opcode_flat[4*(3-k) +: 4]  = out_entry[k][37:34];
         out_imm_flat[8*(3-k) +: 8]     = out_entry[k][33:26];
         out_rt_flat[4*(3-k) +: 4]      = out_entry[k][25:22];
         out_ra_flat[4*(3-k) +: 4]      = out_entry[k][21:18];
         out_rb_flat[4*(3-k) +: 4]      = out_entry[k][17:14];
         out_a_dep_flat[3-k]            = out_entry[k][13];
         out_b_dep_flat[3-k]            = out_entry[k][12];
         out_a_owner_flat[4*(3-k) +: 4] = out_entry[k][11:8];
         out_b_owner_flat[4*(3-k) +: 4] = out_entry[k][7:4];
         out_uses_rb_flat[3-k]          = out_entry[k][3];
         out_is_ld_str_flat[3-k]        = out_entry[k][2];
         out_is_fxu_flat[3-k]           = out_entry[k][1];
         out_is_branch_flat[3-k]        = out_entry[k][0];
      end
   end

   // Status outputs derived from registered state only.
   always_comb begin
      out_count = out_cnt;
      num_free  = (space > FOUR_C) ? 3'd4 : 3'(space);
      overflow  = overflow_q;
   end

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench for instruction_buffer (DEPTH = 8).
module tb_instruction_buffer;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid;
   logic [2:0]  in_count, deq_count;
   logic [15:0] in_opcode_flat, in_rt_flat, in_ra_flat, in_rb_flat;
   logic [31:0] in_imm_flat;
   logic [3:0]  in_a_dep_flat, in_b_dep_flat;
   logic [15:0] in_a_owner_flat, in_b_owner_flat;
   logic [3:0]  in_uses_rb_flat, in_is_ld_str_flat, in_is_fxu_flat, in_is_branch_flat;
   logic [2:0]  num_free, out_count;
   logic [15:0] out_opcode_flat, out_rt_flat, out_ra_flat, out_rb_flat;
   logic [31:0] out_imm_flat;
   logic [3:0]  out_a_dep_flat, out_b_dep_flat;
   logic [15:0] out_a_owner_flat, out_b_owner_flat;
   logic [3:0]  out_uses_rb_flat, out_is_ld_str_flat, out_is_fxu_flat, out_is_branch_flat;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   instruction_buffer #(.DEPTH(8)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_count(in_count),
      .in_opcode_flat(in_opcode_flat), .in_imm_flat(in_imm_flat), .in_rt_flat(in_rt_flat),
      .in_ra_flat(in_ra_flat), .in_rb_flat(in_rb_flat), .in_a_dep_flat(in_a_dep_flat),
      .in_b_dep_flat(in_b_dep_flat), .in_a_owner_flat(in_a_owner_flat),
      .in_b_owner_flat(in_b_owner_flat), .in_uses_rb_flat(in_uses_rb_flat),
      .in_is_ld_str_flat(in_is_ld_str_flat), .in_is_fxu_flat(in_is_fxu_flat),
      .in_is_branch_flat(in_is_branch_flat), .num_free(num_free), .out_count(out_count),
      .out_opcode_flat(out_opcode_flat), .out_imm_flat(out_imm_flat), .out_rt_flat(out_rt_flat),
      .out_ra_flat(out_ra_flat), .out_rb_flat(out_rb_flat), .out_a_dep_flat(out_a_dep_flat),
      .out_b_dep_flat(out_b_dep_flat), .out_a_owner_flat(out_a_owner_flat),
      .out_b_owner_flat(out_b_owner_flat), .out_uses_rb_flat(out_uses_rb_flat),
      .out_is_ld_str_flat(out_is_ld_str_flat), .out_is_fxu_flat(out_is_fxu_flat),
      .out_is_branch_flat(out_is_branch_flat), .deq_count(deq_count), .overflow(overflow)
   );

   // Clock and reset block
   always #5 clk = ~clk;

   // Build a 38-bit record with every field derived from op/imm/rt.
   function automatic logic [37:0] mk(input logic [3:0] op, input logic [7:0] imm,
                                      input logic [3:0] rt);
      return {op, imm, rt, op ^ 4'h5, rt ^ 4'ha, op[0], rt[0],
              op + 4'd1, rt + 4'd2, op};
   endfunction

   function automatic logic [37:0] ent(input logic [3:0] op);
      return mk(op, {op, ~op}, op + 4'd4);
   endfunction

   function automatic logic [37:0] get_lane(input int k);
      return {out_opcode_flat[4*(3-k) +: 4], out_imm_flat[8*(3-k) +: 8],
              out_rt_flat[4*(3-k) +: 4], out_ra_flat[4*(3-k) +: 4],
              out_rb_flat[4*(3-k) +: 4], out_a_dep_flat[3-k], out_b_dep_flat[3-k],
              out_a_owner_flat[4*(3-k) +: 4], out_b_owner_flat[4*(3-k) +: 4],
              out_uses_rb_flat[3-k], out_is_ld_str_flat[3-k], out_is_fxu_flat[3-k],
              out_is_branch_flat[3-k]};
   endfunction

   function automatic logic [151:0] all_out();
      return {out_opcode_flat, out_imm_flat, out_rt_flat, out_ra_flat, out_rb_flat,
              out_a_dep_flat, out_b_dep_flat, out_a_owner_flat, out_b_owner_flat,
              out_uses_rb_flat, out_is_ld_str_flat, out_is_fxu_flat, out_is_branch_flat};
   endfunction

   // Driver tasks
   task automatic set_lane(input int k, input logic [37:0] e);
      in_opcode_flat[4*(3-k) +: 4]  = e[37:34];
      in_imm_flat[8*(3-k) +: 8]     = e[33:26];
      in_rt_flat[4*(3-k) +: 4]      = e[25:22];
      in_ra_flat[4*(3-k) +: 4]      = e[21:18];
      in_rb_flat[4*(3-k) +: 4]      = e[17:14];
      in_a_dep_flat[3-k]            = e[13];
      in_b_dep_flat[3-k]            = e[12];
      in_a_owner_flat[4*(3-k) +: 4] = e[11:8];
      in_b_owner_flat[4*(3-k) +: 4] = e[7:4];
      in_uses_rb_flat[3-k]          = e[3];
      in_is_ld_str_flat[3-k]        = e[2];
      in_is_fxu_flat[3-k]           = e[1];
      in_is_branch_flat[3-k]        = e[0];
   endtask

   task automatic idle_inputs();
      flush = 1'b0; in_valid = 1'b0; in_count = 3'd0; deq_count = 3'd0;
      for (int k = 0; k < 4; k++) set_lane(k, 38'd0);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // One cycle: n lanes starting at opcode op0 (all four lanes carry data).
   task automatic enq(input int n, input logic [3:0] op0, input logic [2:0] dq,
                      input logic fl);
      for (int k = 0; k < 4; k++) set_lane(k, ent(op0 + 4'(k)));
      in_valid = (n > 0); in_count = 3'(n); deq_count = dq; flush = fl;
      cycle();
      idle_inputs();
   endtask

   task automatic test_reset();
      reset = 1'b1; idle_inputs();
      cycle(); cycle();
      reset = 1'b0;
      checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_out_count got %0d exp 0", out_count); end
      checks++; if (num_free !== 3'd4) begin errors++; $display("FAIL reset_num_free got %0d exp 4", num_free); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
      checks++; if (all_out() !== 152'd0) begin errors++; $display("FAIL reset_fields got %h exp 0", all_out()); end
   endtask

   task automatic test_basic();
      enq(4, 4'd1, 3'd0, 1'b0);
      checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL basic_out_count got %0d exp 4", out_count); end
      checks++; if (out_opcode_flat[15:12] !== 4'd1 || out_rt_flat[15:12] !== 4'd5) begin errors++; $display("FAIL basic_lane0 got op %0d rt %0d exp op 1 rt 5", out_opcode_flat[15:12], out_rt_flat[15:12]); end
      checks++; if (out_opcode_flat[3:0] !== 4'd4 || out_rt_flat[3:0] !== 4'd8) begin errors++; $display("FAIL basic_lane3 got op %0d rt %0d exp op 4 rt 8", out_opcode_flat[3:0], out_rt_flat[3:0]); end
      checks++; if (num_free !== 3'd4) begin errors++; $display("FAIL basic_num_free got %0d exp 4", num_free); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (get_lane(k) !== ent(4'(k + 1))) begin errors++; $display("FAIL basic_entry%0d got %h exp %h", k, get_lane(k), ent(4'(k + 1))); end
      end
   endtask

   task automatic test_fill_overflow();
      // Continues from test_basic: count = 4, ops 1..4 stored.
      enq(4, 4'd5, 3'd0, 1'b0);
      checks++; if (num_free !== 3'd0) begin errors++; $display("FAIL full_num_free got %0d exp 0", num_free); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow got %b exp 0", overflow); end
      enq(2, 4'd9, 3'd0, 1'b0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
      checks++; if (num_free !== 3'd0 || out_count !== 3'd4) begin errors++; $display("FAIL ovf_count got free %0d out %0d exp 0 4", num_free, out_count); end
      checks++; if (get_lane(0) !== ent(4'd1) || get_lane(3) !== ent(4'd4)) begin errors++; $display("FAIL ovf_contents got %h %h exp %h %h", get_lane(0), get_lane(3), ent(4'd1), ent(4'd4)); end
      // Full with enqueue attempt and dequeue 2: dequeue still retires.
      enq(2, 4'd9, 3'd2, 1'b0);
      checks++; if (num_free !== 3'd2 || out_count !== 3'd4) begin errors++; $display("FAIL full_deq_count got free %0d out %0d exp 2 4", num_free, out_count); end
      checks++; if (get_lane(0) !== ent(4'd3) || get_lane(3) !== ent(4'd6)) begin errors++; $display("FAIL full_deq_lanes got %h %h exp %h %h", get_lane(0), get_lane(3), ent(4'd3), ent(4'd6)); end
      cycle();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++) set_lane(k, ent(4'(k + 11)));
      reset = 1'b1; in_valid = 1'b1; in_count = 3'd4; deq_count = 3'd2;
      cycle();
      reset = 1'b0; idle_inputs();
      checks++; if (out_count !== 3'd0 || num_free !== 3'd4) begin errors++; $display("FAIL midrst_counts got out %0d free %0d exp 0 4", out_count, num_free); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b exp 0", overflow); end
      cycle();
      checks++; if (all_out() !== 152'd0 || out_count !== 3'd0) begin errors++; $display("FAIL midrst_ignored got out %0d fields %h exp 0", out_count, all_out()); end
   endtask

   task automatic test_wrap();
      enq(4, 4'd1, 3'd0, 1'b0);   // h0 t4 c4
      enq(1, 4'd5, 3'd4, 1'b0);   // h4 t5 c1
      checks++; if (out_count !== 3'd1 || get_lane(0) !== ent(4'd5)) begin errors++; $display("FAIL wrap_step2 got out %0d lane0 %h exp 1 %h", out_count, get_lane(0), ent(4'd5)); end
      enq(4, 4'd6, 3'd1, 1'b0);   // writes idx 5,6,7,0 ; h5 t1 c4
      checks++; if (get_lane(0) !== ent(4'd6) || get_lane(3) !== ent(4'd9)) begin errors++; $display("FAIL wrap_read got %h %h exp %h %h", get_lane(0), get_lane(3), ent(4'd6), ent(4'd9)); end
      enq(2, 4'd10, 3'd0, 1'b0);  // h5 t3 c6
      checks++; if (num_free !== 3'd2) begin errors++; $display("FAIL wrap_c6_free got %0d exp 2", num_free); end
      enq(2, 4'd12, 3'd3, 1'b0);  // h0 t5 c5
      checks++; if (out_count !== 3'd4 || num_free !== 3'd3) begin errors++; $display("FAIL wrap_count got out %0d free %0d exp 4 3", out_count, num_free); end
      checks++; if (get_lane(0) !== ent(4'd9)) begin errors++; $display("FAIL wrap_lane0 got %h exp %h", get_lane(0), ent(4'd9)); end
      checks++; if (get_lane(1) !== ent(4'd10) || get_lane(3) !== ent(4'd12)) begin errors++; $display("FAIL wrap_new3 got %h %h exp %h %h", get_lane(1), get_lane(3), ent(4'd10), ent(4'd12)); end
      enq(1, 4'd14, 3'd1, 1'b0);  // h1 t6 c5
      checks++; if (get_lane(3) !== ent(4'd13) || num_free !== 3'd3) begin errors++; $display("FAIL wrap_new4 got %h free %0d exp %h 3", get_lane(3), num_free, ent(4'd13)); end
   endtask

   task automatic test_flush();
      enq(3, 4'd1, 3'd2, 1'b1);
      checks++; if (out_count !== 3'd0 || num_free !== 3'd4) begin errors++; $display("FAIL flush_counts got out %0d free %0d exp 0 4", out_count, num_free); end
      checks++; if (all_out() !== 152'd0) begin errors++; $display("FAIL flush_fields got %h exp 0", all_out()); end
   endtask

   task automatic test_partial_clamp();
      set_lane(0, mk(4'd1, 8'h11, 4'd5));
      set_lane(1, mk(4'd2, 8'h22, 4'd6));
      set_lane(2, mk(4'd3, 8'h33, 4'd7));
      set_lane(3, mk(4'd4, 8'h44, 4'd8));
      in_valid = 1'b1; in_count = 3'd3;
      #1;
      checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL no_bypass got %0d exp 0", out_count); end
      cycle();
      idle_inputs();
      checks++; if (out_count !== 3'd3 || num_free !== 3'd4) begin errors++; $display("FAIL part_counts got out %0d free %0d exp 3 4", out_count, num_free); end
      checks++; if (out_imm_flat !== 32'h1122_3300) begin errors++; $display("FAIL part_imm got %h exp 11223300", out_imm_flat); end
      checks++; if (get_lane(3) !== 38'd0) begin errors++; $display("FAIL part_lane3 got %h exp 0", get_lane(3)); end
      checks++; if (get_lane(1) !== mk(4'd2, 8'h22, 4'd6)) begin errors++; $display("FAIL part_lane1 got %h exp %h", get_lane(1), mk(4'd2, 8'h22, 4'd6)); end
      deq_count = 3'd4;
      cycle();
      idle_inputs();
      checks++; if (out_count !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL clamp got out %0d ovf %b exp 0 0", out_count, overflow); end
      enq(1, 4'd7, 3'd0, 1'b0);
      checks++; if (out_count !== 3'd1 || get_lane(0) !== ent(4'd7)) begin errors++; $display("FAIL clamp_head got out %0d lane0 %h exp 1 %h", out_count, get_lane(0), ent(4'd7)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_overflow();
      test_reset_mid();
      test_wrap();
      test_flush();
      test_partial_clamp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_buffer.md
# instruction_buffer

Circular queue that sits between instruction fetch/decode and dispatch. Each cycle it accepts up to four decoded instructions, in program order, from fetch. It presents up to four of the oldest entries to dispatch and retires however many dispatch consumes. It drives the free-slot count that fetch uses as its `num_fetch` request size, and it empties in one cycle on a redirect.

## Interface
- `DEPTH`, 8, number of entries; must be a power of two and at least 4.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: redirect (taken jump or mispredict); empties the buffer.
- `in_valid` in 1: the fetch bundle is valid (driven from fetch `if_valid_out`).
- `in_count` in 3: number of valid lanes, 0–4. Lanes 0..in_count-1 are valid.
- `in_opcode_flat` in 16: 4 bits per lane.
- `in_imm_flat` in 32: 8 bits per lane.
- `in_rt_flat`, `in_ra_flat`, `in_rb_flat` in 16 each: 4 bits per lane.
- `in_a_dep_flat`, `in_b_dep_flat` in 4 each: 1 bit per lane.
- `in_a_owner_flat`, `in_b_owner_flat` in 16 each: 4 bits per lane.
- `in_uses_rb_flat`, `in_is_ld_str_flat`, `in_is_fxu_flat`, `in_is_branch_flat` in 4 each: 1 bit per lane.
- `num_free` out 3: min(free entries, 4); feeds fetch `num_fetch`.
- `out_count` out 3: min(occupancy, 4); number of valid output lanes.
- `out_*_flat` out: same 13 fields and widths as the `in_*_flat` ports. Lane 0 holds the oldest entry.
- `deq_count` in 3: number of entries dispatch consumes this cycle, 0–4.
- `overflow` out 1: sticky error flag.
- Flat lane packing, all buses: lane k occupies bits [W*(3-k)+W-1 : W*(3-k)], so lane 0 is in the MSBs.

## Operation
- Entry: 38-bit record holding all 13 fields; stored and returned unmodified.
- State:
  - `head` and `tail`: log2(DEPTH) bits each, wrap modulo DEPTH.
  - `count`: log2(DEPTH)+1 bits, range 0..DEPTH.
- Enqueue amount:
  - enq = in_valid && !flush ? min(in_count, DEPTH-count) : 0.
  - Lane k (k < enq) is written to entry (tail+k) mod DEPTH; tail advances by enq.
- Overflow:
  - Occurs when in_valid, !flush and in_count > DEPTH-count.
  - Set `overflow` and drop the excess lanes, highest-numbered first.
  - `overflow` clears only on reset.
- Dequeue amount:
  - deq = flush ? 0 : min(deq_count, out_count); head advances by deq.
  - deq_count > out_count is clamped to out_count and does not set the error flag.
- Count update: count_next = count + enq - deq.
  - Enqueue space is computed from count before dequeue, so space freed by a same-cycle dequeue is not reusable in that cycle.
- Flush:
  - head, tail and count are set to 0.
  - Same-cycle enqueue and dequeue are discarded.
  - Stored data is not cleared.
  - flush together with reset behaves as reset.
- Outputs (combinational from registered state only; no input reaches an output combinationally):
  - `out_count` = min(count, 4).
  - Output lane k = entry (head+k) mod DEPTH for k < out_count; all fields of lane k are 0 for k ≥ out_count.
  - `num_free` = min(DEPTH-count, 4).
- Wrap-around: reads and writes that cross index DEPTH-1 → 0 are handled within the same cycle.

## Timing
- Reset values, at the first edge with reset high:
  - head = tail = count = 0.
  - `out_count` = 0.
  - All `out_*` fields = 0.
  - `num_free` = min(DEPTH, 4) = 4.
  - `overflow` = 0.
- Latency:
  - An entry written at edge N appears on the output lanes after edge N, i.e. it can be dispatched in cycle N+1.
  - Minimum fetch-to-dispatch latency is 1 cycle.
- `num_free` in cycle N reflects state after edge N-1. Fetch sizes its request from it, so a fetch that respects `num_free` never overflows.
- Simultaneous enqueue and dequeue in one cycle is supported. The full and empty boundaries follow the formulas above.
- Full (count = DEPTH):
  - `num_free` = 0; any nonzero in_count with in_valid sets `overflow`.
  - A same-cycle dequeue still retires entries.
- Empty (count = 0):
  - `out_count` = 0 and deq is forced to 0.
  - An enqueue this cycle becomes visible next cycle; there is no bypass.
- Reset asserted mid-operation: all state returns to reset values at that edge, and inputs are ignored while reset is high.

## Test plan
- Reset:
  - Stimulus: hold reset 2 cycles, then release.
  - Required: `out_count` = 0, `num_free` = 4, `overflow` = 0, all `out_*` fields = 0.
- Basic enqueue and order:
  - Stimulus: enqueue 4 lanes with opcodes 1, 2, 3, 4 and rt 5, 6, 7, 8.
  - Required: next cycle `out_count` = 4, lane 0 opcode = 1 / rt = 5, lane 3 opcode = 4 / rt = 8, `num_free` = 4 (DEPTH-4).
- Fill and overflow:
  - Stimulus: enqueue 4, then 4 → `num_free` = 0. Then in_valid with in_count = 2 and deq_count = 0.
  - Required: `overflow` = 1, count stays 8, contents unchanged.
- Wrap with simultaneous enqueue/dequeue:
  - Stimulus: with count = 6 and head = 5, enqueue 2 and set deq_count = 3 in the same cycle.
  - Required: count = 5, head = 0, lane 0 = the 4th-oldest original entry, new entries at indices 3 and 4.
- Flush precedence:
  - Stimulus: with count = 5, assert flush together with in_count = 3 and deq_count = 2.
  - Required: next cycle count = 0, `out_count` = 0, `num_free` = 4.
- Partial bundle and clamp:
  - Stimulus: enqueue in_count = 3 (imm 0x11, 0x22, 0x33), then deq_count = 4.
  - Required: `out_count` = 3 with lane 3 all-zero; after the dequeue `out_count` = 0 and `overflow` = 0.
